// File: rtl/addtree_arb.sv
// addtree_arb: shares one pipelined four-operand addtree between NREQ requesters.
// One requester is granted per cycle. Its operands are steered into the adder, and its
// ID travels down a LAT-deep tag pipeline so that each sum comes back tagged.
// An enable/drain state machine lets software quiesce the adder without
// dropping sums that are already in flight.
// Build option: define ADDTREE_ARB_RR_EN for round-robin arbitration; without it
// the arbiter is fixed priority (lowest index wins) and has no pointer register.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | quiescent, no grants; idle asserted once tags are empty
// ST_RUN   | arbitrating, at most one grant per cycle
// ST_DRAIN | enable dropped, no grants, waiting for in-flight tags to exit

module addtree_arb #(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 64,
   parameter  int LAT   = 1,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] op_a,
   input  logic [NREQ*WIDTH-1:0] op_b,
   input  logic [NREQ*WIDTH-1:0] op_c,
   input  logic [NREQ*WIDTH-1:0] op_d,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      add_a,
   output logic [WIDTH-1:0]      add_b,
   output logic [WIDTH-1:0]      add_c,
   output logic [WIDTH-1:0]      add_d,
   input  logic [WIDTH-1:0]      add_q,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_q,
   output logic                  idle
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic             win_found;
   logic [IDW-1:0]   win_id;
   logic             grant_any;

   logic [LAT-1:0]   tag_vld;
   logic [LAT-1:0]   vld_nxt;
   logic [IDW-1:0]   tag_id [LAT];

`ifdef ADDTREE_ARB_RR_EN
   logic [IDW-1:0]   ptr;

   // Round-robin search: start at ptr, wrap modulo NREQ, first set request wins.
   always_comb begin
      int cand;
      win_found = 1'b0;
      win_id    = '0;
      cand      = 0;
      for (int i = 0; i < NREQ; i++) begin
         cand = int'(ptr) + i;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_id    = IDW'(cand);
         end
      end
   end

   // Pointer moves one past the winner after every grant and holds otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
      end else if (grant_any) begin
         if (win_id == IDW'(NREQ - 1)) begin
            ptr <= '0;
         end else begin
            ptr <= win_id + 1'b1;
         end
      end
   end
`else
   // Fixed priority search: the lowest-index set request wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!win_found && req[i]) begin
            win_found = 1'b1;
            win_id    = IDW'(i);
         end
      end
   end
`endif

   // A grant only leaves the arbiter in RUN; IDLE and DRAIN mask it off.
   always_comb begin
      grant_any = win_found && (state == ST_RUN);
      gnt       = '0;
      for (int i = 0; i < NREQ; i++) begin
         gnt[i] = grant_any && (win_id == IDW'(i));
      end
   end

   // Steer the granted requester's operands into the adder; zeros when idle.
   always_comb begin
      add_a = '0;
      add_b = '0;
      add_c = '0;
      add_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            add_a = op_a[i*WIDTH +: WIDTH];
            add_b = op_b[i*WIDTH +: WIDTH];
            add_c = op_c[i*WIDTH +: WIDTH];
            add_d = op_d[i*WIDTH +: WIDTH];
         end
      end
   end

   // Valid bits as they will look after the next edge. DRAIN uses this, so IDLE is
   // reached on the cycle right after the last response, not one cycle later.
   always_comb begin
      vld_nxt    = '0;
      vld_nxt[0] = grant_any;
      for (int i = 1; i < LAT; i++) begin
         vld_nxt[i] = tag_vld[i-1];
      end
   end

   // Tag pipeline shift; reset drops every in-flight tag at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_vld <= '0;
         for (int i = 0; i < LAT; i++) begin
            tag_id[i] <= '0;
         end
      end else begin
         tag_vld   <= vld_nxt;
         tag_id[0] <= grant_any ? win_id : '0;
         for (int i = 1; i < LAT; i++) begin
            tag_id[i] <= tag_id[i-1];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; re-enabling during DRAIN resumes RUN without waiting.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (enable) begin
               state_nxt = ST_RUN;
            end else if (!(|vld_nxt)) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Response side: the last tag stage qualifies the adder result.
   always_comb begin
      rsp_valid = tag_vld[LAT-1];
      rsp_id    = tag_id[LAT-1];
      rsp_q     = add_q;
      idle      = (state == ST_IDLE) && !(|tag_vld);
   end

endmodule
